lb_master: RTL and testbench
============================

# lb_master

Local Bus initiator that turns a valid/ready command stream into single Local Bus read or write transactions and returns one response per command. It sits between a host-side command source (UART/JTAG/AXI-Lite bridge front end) and any generated register map responder. It handles one outstanding transaction at a time. A timeout aborts transactions the responder never completes.

## Interface
- ADDR_W, 12, LB address width
- DATA_W, 32, LB data width
- STRB_W, DATA_W/8, byte strobe width
- TIMEOUT, 255, maximum cycles a strobe is held waiting for wready/rvalid (≥2)

Clock is `clk`. Reset is `rst`. One clock; reset is synchronous and active-high.

- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  STRB_W  write byte strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_W  read data; 0 for writes; ERR_DATA on timeout
- rsp_err  out  1  transaction timed out
- lb_waddr, lb_wdata, lb_wstrb  out  ADDR_W/DATA_W/STRB_W  write channel
- lb_wen  out  1  write strobe
- lb_wready  in  1  write accepted
- lb_raddr  out  ADDR_W  read address
- lb_ren  out  1  read strobe
- lb_rdata  in  DATA_W  read data
- lb_rvalid  in  1  read data valid

## Operation
- FSM states: IDLE, WRITE, READ, RESP.
- cmd_ready = (state==IDLE) && !rst.
- IDLE: on command handshake:
  - Register addr, wdata and wstrb into the lb_* outputs.
  - Go to WRITE (lb_wen<=1) or READ (lb_ren<=1).
  - Clear the timeout counter.
- WRITE:
  - lb_wen, lb_waddr, lb_wdata and lb_wstrb are held stable until a cycle with lb_wready=1.
  - On that cycle: lb_wen<=0, rsp_err<=0, rsp_rdata<=0, go to RESP.
- READ:
  - lb_ren and lb_raddr are held stable until a cycle with lb_rvalid=1.
  - On that cycle: capture lb_rdata into rsp_rdata, lb_ren<=0, rsp_err<=0, go to RESP.
- Timeout:
  - The counter increments each WRITE/READ cycle with no handshake.
  - If the handshake is still absent in the TIMEOUT-th cycle of the strobe, drop the strobe and go to RESP with rsp_err=1 and rsp_rdata=ERR_DATA.
  - A handshake in the same cycle as expiry wins: normal completion, rsp_err=0.
- RESP:
  - rsp_valid=1 with rsp_rdata and rsp_err stable until rsp_ready.
  - On rsp_ready, go to IDLE and deassert rsp_valid.
- lb_rvalid or lb_wready arriving while in IDLE or RESP (late, after abort) is ignored.
- Reset mid-transaction:
  - Next edge: state=IDLE; lb_wen, lb_ren, rsp_valid and rsp_err all 0.
  - The pending response is discarded.
- Reset values:
  - lb_wen=0, lb_ren=0, lb_waddr/lb_raddr/lb_wdata/lb_wstrb=0.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - cmd_ready=0 while rst=1.

## Timing
- All outputs except cmd_ready are registered.
- Write, responder with wready tied 1:
  - cmd handshake at T, lb_wen=1 at T+1, lb_wen=0 and rsp_valid=1 at T+2.
- Read, responder with registered rvalid:
  - handshake at T, lb_ren=1 at T+1, lb_rvalid=1 at T+2, lb_ren=0 and rsp_valid=1 at T+3.
- lb_ren stays high in the cycle lb_rvalid is sampled. The responder's rvalid therefore self-clears; exactly one rvalid pulse per read.
- Back-to-back throughput with rsp_ready=1:
  - the next cmd is accepted in the cycle after rsp handshake;
  - write 3 cycles/command, read 4 cycles/command.
- Timeout counter width = $clog2(TIMEOUT+1). No wrap is possible because the count saturates at expiry.

## Structure
- Package lb_pkg:
  - state enum (IDLE, WRITE, READ, RESP);
  - ERR_DATA constant = 32'hdeadbeef, matching the responder default read data.
- One sub-module, lb_timeout_cnt: clear/enable inputs, parameter TIMEOUT, output expired.
- FSM and datapath registers live in lb_master.

## Test plan
- Write 0x0 with data 0xA5A5_1234, wstrb 4'b0011, against the generated responder:
  - lb_wen high exactly 1 cycle;
  - responder LEN = 0x0000_1234;
  - rsp_valid at T+2 with rsp_err=0, rsp_rdata=0.
- Read 0x40 (VERSION):
  - lb_ren high 2 cycles;
  - rsp_rdata=0x0002_0023 at T+3, rsp_err=0.
- Stub responder holding wready=0, TIMEOUT=8:
  - lb_wen high exactly 8 cycles then drops;
  - rsp_err=1, rsp_rdata=0xdeadbeef;
  - a late wready in RESP is ignored.
- Read with rsp_ready held 0 for 5 cycles:
  - rsp_valid and rsp_rdata stable throughout;
  - cmd_ready=0 until the response handshake, then the next command is accepted the following cycle.
- rst asserted while lb_ren=1 awaiting rvalid:
  - next cycle lb_ren=0, rsp_valid=0;
  - after rst release the first command completes normally.
- Stub responder asserting lb_wready or lb_rvalid in exactly the TIMEOUT-th strobe cycle:
  - normal completion, rsp_err=0;
  - for the read case, rsp_rdata = stub data.

Source files
------------

// File: rtl/lb_pkg.sv
// Shared types and constants for the Local Bus initiator and its responders.
package lb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } lb_state_e;

  // Same pattern the register-map responder returns for unmapped reads.
  localparam logic [31:0] ERR_DATA = 32'hdead_beef;

endpackage

// File: rtl/lb_if.sv
// Command/response stream plus Local Bus channels between a host front end, lb_master and a responder.
interface lb_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] lb_waddr;
  logic [DATA_W-1:0] lb_wdata;
  logic [STRB_W-1:0] lb_wstrb;
  logic              lb_wen;
  logic              lb_wready;
  logic [ADDR_W-1:0] lb_raddr;
  logic              lb_ren;
  logic [DATA_W-1:0] lb_rdata;
  logic              lb_rvalid;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  lb_wready, lb_rdata, lb_rvalid,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output lb_waddr, lb_wdata, lb_wstrb, lb_wen, lb_raddr, lb_ren
  );

  modport slave (
    input  lb_waddr, lb_wdata, lb_wstrb, lb_wen, lb_raddr, lb_ren,
    output lb_wready, lb_rdata, lb_rvalid
  );
endinterface

// File: rtl/lb_timeout_cnt.sv
// Saturating strobe-age counter; expired is high in the TIMEOUT-th enabled cycle after clear.
module lb_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Count enabled cycles, holding at LAST so the counter can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable && (cnt_r != LAST)) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == LAST);

endmodule

// File: rtl/lb_master.sv
// Local Bus initiator: one command in, one single-beat LB transaction, one response out.
module lb_master
  import lb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  lb_if.master bus
);
  lb_state_e state_r;
  logic      cmd_fire_s;
  logic      cnt_en_s;
  logic      expired_s;

  assign bus.cmd_ready = (state_r == IDLE) && !rst;
  assign cmd_fire_s    = bus.cmd_valid && bus.cmd_ready;
  assign cnt_en_s      = (state_r == WRITE) || (state_r == READ);

  lb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (cmd_fire_s),
    .enable  (cnt_en_s),
    .expired (expired_s)
  );

  // Transaction FSM with registered bus and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      bus.lb_wen    <= 1'b0;
      bus.lb_ren    <= 1'b0;
      bus.lb_waddr  <= '0;
      bus.lb_raddr  <= '0;
      bus.lb_wdata  <= '0;
      bus.lb_wstrb  <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_fire_s && bus.cmd_write) begin
            bus.lb_waddr <= bus.cmd_addr;
            bus.lb_wdata <= bus.cmd_wdata;
            bus.lb_wstrb <= bus.cmd_wstrb;
            bus.lb_wen   <= 1'b1;
            state_r      <= WRITE;
          end else if (cmd_fire_s) begin
            bus.lb_raddr <= bus.cmd_addr;
            bus.lb_ren   <= 1'b1;
            state_r      <= READ;
          end
        end
        // A handshake in the expiry cycle is checked first, so it completes normally.
        WRITE: begin
          if (bus.lb_wready) begin
            bus.lb_wen    <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_valid <= 1'b1;
            state_r       <= RESP;
          end else if (expired_s) begin
            bus.lb_wen    <= 1'b0;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= DATA_W'(ERR_DATA);
            bus.rsp_valid <= 1'b1;
            state_r       <= RESP;
          end
        end
        READ: begin
          if (bus.lb_rvalid) begin
            bus.lb_ren    <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= bus.lb_rdata;
            bus.rsp_valid <= 1'b1;
            state_r       <= RESP;
          end else if (expired_s) begin
            bus.lb_ren    <= 1'b0;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= DATA_W'(ERR_DATA);
            bus.rsp_valid <= 1'b1;
            state_r       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state_r       <= IDLE;
          end
        end
        default: begin
          bus.lb_wen    <= 1'b0;
          bus.lb_ren    <= 1'b0;
          bus.rsp_valid <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lb_master.sv
// Directed bench for lb_master: small register responder model plus a manual stub for timeout corners.
module tb_lb_master;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lb_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  lb_master #(.DATA_W(32), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Responder model: LEN at 0x000 (byte-strobed), VERSION at 0x040, self-clearing registered rvalid.
  logic [31:0] len_r;
  logic        rv_r;
  logic [31:0] model_rdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      len_r <= 32'd0;
      rv_r  <= 1'b0;
    end else begin
      rv_r <= bus.lb_ren && !rv_r;
      if (bus.lb_wen && bus.lb_wready && bus.lb_waddr == 12'h000) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.lb_wstrb[b]) len_r[8*b +: 8] <= bus.lb_wdata[8*b +: 8];
        end
      end
    end
  end
  assign model_rdata = (bus.lb_raddr == 12'h000) ? len_r :
                       (bus.lb_raddr == 12'h040) ? 32'h0002_0023 : 32'hdead_beef;

  logic        stub_mode = 1'b0;
  logic        stub_wready = 1'b0;
  logic        stub_rvalid = 1'b0;
  logic [31:0] stub_rdata = 32'd0;
  assign bus.lb_wready = stub_mode ? stub_wready : 1'b1;
  assign bus.lb_rvalid = stub_mode ? stub_rvalid : rv_r;
  assign bus.lb_rdata  = stub_mode ? stub_rdata  : model_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_strobe;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command and wait (bounded) for its handshake; leaves us in cycle T+1.
  task automatic start_cmd(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, output int waited);
    logic hs;
    hs = 1'b0;
    waited = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_wstrb = wstrb;
    for (int i = 0; i < 20; i++) begin
      hs = bus.cmd_ready;
      step();
      if (hs) break;
      waited++;
    end
    bus.cmd_valid = 1'b0;
    chk("cmd_accept", 32'(hs), 32'd1);
  endtask

  // lat counts cycles from the current one (1) up to the one showing rsp_valid.
  task automatic wait_rsp(output int lat, output int strobe);
    lat = 1;
    strobe = 0;
    while (!bus.rsp_valid && lat < 40) begin
      if (bus.lb_wen || bus.lb_ren) strobe++;
      step();
      lat++;
    end
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int w, lat, st;
    start_cmd(v.wr, v.addr, v.wdata, v.wstrb, w);
    wait_rsp(lat, st);
    chk({tag, "_lat"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, "_strobe"}, 32'(st), 32'(v.exp_strobe));
    chk({tag, "_rdata"}, bus.rsp_rdata, v.exp_rdata);
    chk({tag, "_err"}, 32'(bus.rsp_err), 32'(v.exp_err));
    finish_rsp();
  endtask

  initial begin
    int w, lat, st;
    vecs[0] = '{1'b1, 12'h000, 32'hA5A5_1234, 4'b0011, 32'h0000_0000, 1'b0, 2, 1};
    vecs[1] = '{1'b0, 12'h000, 32'h0,         4'b0000, 32'h0000_1234, 1'b0, 3, 2};
    vecs[2] = '{1'b0, 12'h040, 32'h0,         4'b0000, 32'h0002_0023, 1'b0, 3, 2};
    vecs[3] = '{1'b1, 12'h000, 32'hFFFF_FFFF, 4'b1000, 32'h0000_0000, 1'b0, 2, 1};
    vecs[4] = '{1'b0, 12'h000, 32'h0,         4'b0000, 32'hFF00_1234, 1'b0, 3, 2};
    vecs[5] = '{1'b0, 12'h044, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0, 3, 2};
    vecs[6] = '{1'b1, 12'h000, 32'h00C3_0000, 4'b0100, 32'h0000_0000, 1'b0, 2, 1};
    vecs[7] = '{1'b0, 12'h000, 32'h0,         4'b0000, 32'hFFC3_1234, 1'b0, 3, 2};

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 12'h000;
    bus.cmd_wdata = 32'd0;
    bus.cmd_wstrb = 4'd0;
    bus.rsp_ready = 1'b0;

    // Reset values
    repeat (3) step();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_wen", 32'(bus.lb_wen), 32'd0);
    chk("rst_ren", 32'(bus.lb_ren), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_waddr", 32'(bus.lb_waddr), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Response back-pressure on a read, then immediate acceptance of the next command
    start_cmd(1'b0, 12'h040, 32'd0, 4'd0, w);
    wait_rsp(lat, st);
    chk("bp_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rdata", bus.rsp_rdata, 32'h0002_0023);
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      step();
    end
    finish_rsp();
    chk("bp_next_ready", 32'(bus.cmd_ready), 32'd1);
    start_cmd(1'b1, 12'h000, 32'h0000_0077, 4'b0001, w);
    chk("bp_next_wait", 32'(w), 32'd0);
    wait_rsp(lat, st);
    chk("bp_next_lat", 32'(lat), 32'd2);
    finish_rsp();

    // Write timeout with wready held low, then a late wready in RESP
    stub_mode = 1'b1;
    start_cmd(1'b1, 12'h000, 32'h1111_2222, 4'b1111, w);
    wait_rsp(lat, st);
    chk("to_w_strobe", 32'(st), 32'(TO));
    chk("to_w_lat", 32'(lat), 32'(TO + 1));
    chk("to_w_err", 32'(bus.rsp_err), 32'd1);
    chk("to_w_rdata", bus.rsp_rdata, 32'hdead_beef);
    stub_wready = 1'b1;
    repeat (2) begin
      step();
      chk("late_valid", 32'(bus.rsp_valid), 32'd1);
      chk("late_err", 32'(bus.rsp_err), 32'd1);
      chk("late_rdata", bus.rsp_rdata, 32'hdead_beef);
      chk("late_wen", 32'(bus.lb_wen), 32'd0);
    end
    stub_wready = 1'b0;
    finish_rsp();

    // Write handshake in exactly the TIMEOUT-th strobe cycle
    start_cmd(1'b1, 12'h010, 32'h3333_4444, 4'b1111, w);
    repeat (TO - 1) step();
    chk("edge_w_wen", 32'(bus.lb_wen), 32'd1);
    stub_wready = 1'b1;
    wait_rsp(lat, st);
    stub_wready = 1'b0;
    chk("edge_w_lat", 32'(lat), 32'd2);
    chk("edge_w_err", 32'(bus.rsp_err), 32'd0);
    chk("edge_w_rdata", bus.rsp_rdata, 32'd0);
    finish_rsp();

    // Read rvalid in exactly the TIMEOUT-th strobe cycle
    stub_rdata = 32'h1234_5678;
    start_cmd(1'b0, 12'h020, 32'd0, 4'd0, w);
    repeat (TO - 1) step();
    chk("edge_r_ren", 32'(bus.lb_ren), 32'd1);
    stub_rvalid = 1'b1;
    wait_rsp(lat, st);
    stub_rvalid = 1'b0;
    chk("edge_r_lat", 32'(lat), 32'd2);
    chk("edge_r_err", 32'(bus.rsp_err), 32'd0);
    chk("edge_r_rdata", bus.rsp_rdata, 32'h1234_5678);
    finish_rsp();

    // Reset while a read strobe waits for rvalid
    start_cmd(1'b0, 12'h040, 32'd0, 4'd0, w);
    chk("mid_ren", 32'(bus.lb_ren), 32'd1);
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("mid_rst_ren", 32'(bus.lb_ren), 32'd0);
    chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_err", 32'(bus.rsp_err), 32'd0);
    chk("mid_rst_ready", 32'(bus.cmd_ready), 32'd0);
    rst = 1'b0;
    stub_mode = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
    run_vec(vecs[2], "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
